dtw_row_engine: RTL and testbench

- Downstream consumer of the AXIS sink FIFO in the DTW accelerator.
- Pops 8-bit query samples through the sink's read interface (dtw_fifo_rden, dtw_fifo_dout, dtw_fifo_empty).
- Runs subsequence DTW against a reference squiggle held in a local register bank, one column per cycle.
- Reports the minimum last-row cost and its column.

---
 rtl/dtw_row_engine.sv | 178 +++++++++++++++++
 tb/tb_dtw_row_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_row_engine.sv
`default_nettype none
// ============================================================================
// Module  : dtw_row_engine
// Brief   : Subsequence DTW against a local reference bank, one column per
//           cycle, fed from a first-word-fall-through FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module dtw_row_engine #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int REF_LEN      = 16,
  parameter int COST_WIDTH   = 16,
  parameter int QLEN_WIDTH   = 16,
  localparam int AW          = (REF_LEN > 1) ? $clog2(REF_LEN) : 1
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    start,
  input  logic [QLEN_WIDTH-1:0]   qry_len,
  input  logic                    ref_wr_en,
  input  logic [AW-1:0]           ref_wr_addr,
  input  logic [SAMPLE_WIDTH-1:0] ref_wr_data,
  output logic                    dtw_fifo_rden,
  input  logic [SAMPLE_WIDTH-1:0] dtw_fifo_dout,
  input  logic                    dtw_fifo_empty,
  output logic                    busy,
  output logic                    done,
  output logic [COST_WIDTH-1:0]   score,
  output logic [AW-1:0]           score_pos
);

  localparam logic [AW-1:0]         J_LAST   = AW'(REF_LEN - 1);
  localparam logic [COST_WIDTH-1:0] COST_MAX = {COST_WIDTH{1'b1}};
  localparam logic [QLEN_WIDTH-1:0] QLEN_ONE = QLEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ROW    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                  state_q;
  logic [SAMPLE_WIDTH-1:0] ref_q [REF_LEN];
  logic [COST_WIDTH-1:0]   row_q [REF_LEN];
  logic [SAMPLE_WIDTH-1:0] q_q;
  logic [AW-1:0]           j_q;
  logic [QLEN_WIDTH-1:0]   row_idx_q;
  logic [QLEN_WIDTH-1:0]   qlen_q;
  logic [COST_WIDTH-1:0]   left_q;
  logic [COST_WIDTH-1:0]   diag_q;
  logic [COST_WIDTH-1:0]   min_q;
  logic [AW-1:0]           argmin_q;
  logic [COST_WIDTH-1:0]   score_q;
  logic [AW-1:0]           score_pos_q;
  logic                    done_q;

  logic [SAMPLE_WIDTH-1:0] ref_d;
  logic [SAMPLE_WIDTH-1:0] absdiff_d;
  logic [COST_WIDTH-1:0]   dist_d;
  logic [COST_WIDTH-1:0]   up_d;
  logic [COST_WIDTH-1:0]   min_ud_d;
  logic [COST_WIDTH-1:0]   min3_d;
  logic [COST_WIDTH-1:0]   addend_d;
  logic [COST_WIDTH:0]     sum_d;
  logic [COST_WIDTH-1:0]   cell_d;
  logic                    last_row_d;

  assign ref_d     = ref_q[j_q];
  assign absdiff_d = (q_q >= ref_d) ? (q_q - ref_d) : (ref_d - q_q);

  // Fit the sample distance into the cost width, clamping if the cost is narrower.
  generate
    if (COST_WIDTH > SAMPLE_WIDTH) begin : g_dist_pad
      assign dist_d = {{(COST_WIDTH-SAMPLE_WIDTH){1'b0}}, absdiff_d};
    end else if (COST_WIDTH == SAMPLE_WIDTH) begin : g_dist_fit
      assign dist_d = absdiff_d;
    end else begin : g_dist_clamp
      assign dist_d = (|absdiff_d[SAMPLE_WIDTH-1:COST_WIDTH]) ? COST_MAX
                                                             : absdiff_d[COST_WIDTH-1:0];
    end
  endgenerate

  assign up_d       = row_q[j_q];
  assign min_ud_d   = (up_d < diag_q) ? up_d : diag_q;
  assign min3_d     = (min_ud_d < left_q) ? min_ud_d : left_q;
  assign addend_d   = (row_idx_q == '0) ? '0 : ((j_q == '0) ? up_d : min3_d);
  assign sum_d      = {1'b0, dist_d} + {1'b0, addend_d};
  assign cell_d     = sum_d[COST_WIDTH] ? COST_MAX : sum_d[COST_WIDTH-1:0];
  assign last_row_d = (row_idx_q == (qlen_q - QLEN_ONE));

  assign dtw_fifo_rden = (state_q == S_FETCH) && !dtw_fifo_empty;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign score         = score_q;
  assign score_pos     = score_pos_q;

  // Reference bank is deliberately outside reset so it survives a mid-run abort.
  always_ff @(posedge ACLK) begin
    if ((state_q == S_IDLE) && ref_wr_en) begin
      ref_q[ref_wr_addr] <= ref_wr_data;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      j_q         <= '0;
      row_idx_q   <= '0;
      qlen_q      <= '0;
      left_q      <= '0;
      diag_q      <= '0;
      min_q       <= '0;
      argmin_q    <= '0;
      score_q     <= '0;
      score_pos_q <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < REF_LEN; i++) begin
        row_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (qry_len != '0) begin
              qlen_q    <= qry_len;
              row_idx_q <= '0;
              state_q   <= S_FETCH;
            end else begin
              done_q      <= 1'b1;
              score_q     <= COST_MAX;
              score_pos_q <= '0;
            end
          end
        end
        S_FETCH: begin
          if (!dtw_fifo_empty) begin
            q_q     <= dtw_fifo_dout;
            j_q     <= '0;
            left_q  <= COST_MAX;
            diag_q  <= COST_MAX;
            state_q <= S_ROW;
          end
        end
        S_ROW: begin
          row_q[j_q] <= cell_d;
          left_q     <= cell_d;
          diag_q     <= up_d;
          // Column 0 seeds the running min; later columns need strictly smaller.
          if (last_row_d && ((j_q == '0) || (cell_d < min_q))) begin
            min_q    <= cell_d;
            argmin_q <= j_q;
          end
          if (j_q == J_LAST) begin
            if (last_row_d) begin
              state_q <= S_FINISH;
            end else begin
              row_idx_q <= row_idx_q + QLEN_ONE;
              state_q   <= S_FETCH;
            end
          end else begin
            j_q <= j_q + AW'(1);
          end
        end
        S_FINISH: begin
          score_q     <= min_q;
          score_pos_q <= argmin_q;
          done_q      <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dtw_row_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_dtw_row_engine
// Brief   : Directed self-checking bench for dtw_row_engine (COST_WIDTH=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_dtw_row_engine;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic [15:0] qry_len = '0;
  logic        ref_wr_en = 1'b0;
  logic [3:0]  ref_wr_addr = '0;
  logic [7:0]  ref_wr_data = '0;
  logic        dtw_fifo_rden;
  logic [7:0]  dtw_fifo_dout = '0;
  logic        dtw_fifo_empty = 1'b1;
  logic        busy;
  logic        done;
  logic [7:0]  score;
  logic [3:0]  score_pos;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  fifo[$];
  logic        stall = 1'b0;
  bit          stall_req = 1'b0;
  int          stall_left = 0;
  int          pops = 0;
  int          rden_cycles = 0;
  int          rden_in_stall = 0;
  int          lat = 0;

  dtw_row_engine #(
    .SAMPLE_WIDTH(8),
    .REF_LEN     (16),
    .COST_WIDTH  (8),
    .QLEN_WIDTH  (16)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .start         (start),
    .qry_len       (qry_len),
    .ref_wr_en     (ref_wr_en),
    .ref_wr_addr   (ref_wr_addr),
    .ref_wr_data   (ref_wr_data),
    .dtw_fifo_rden (dtw_fifo_rden),
    .dtw_fifo_dout (dtw_fifo_dout),
    .dtw_fifo_empty(dtw_fifo_empty),
    .busy          (busy),
    .done          (done),
    .score         (score),
    .score_pos     (score_pos)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fifo_drive();
    stall          = (stall_left > 0);
    dtw_fifo_empty = stall || (fifo.size() == 0);
    dtw_fifo_dout  = (fifo.size() > 0) ? fifo[0] : 8'd0;
  endtask

  // One clock: sample the pop request mid-cycle, advance, then update the FIFO model.
  task automatic tick();
    logic pop;
    #2;
    pop = dtw_fifo_rden && !dtw_fifo_empty;
    if (dtw_fifo_rden) rden_cycles++;
    if (dtw_fifo_rden && stall) rden_in_stall++;
    if (stall) stall_left--;
    @(posedge ACLK);
    #1;
    if (pop) begin
      void'(fifo.pop_front());
      pops++;
      // Empty for the 16 ROW cycles of row 0 plus 10 cycles in FETCH.
      if (stall_req && pops == 1) begin
        stall_left = 26;
        stall_req  = 1'b0;
      end
    end
    fifo_drive();
  endtask

  task automatic load_ref(input bit zero);
    for (int j = 0; j < 16; j++) begin
      logic [7:0] v;
      v           = 8'(j);
      ref_wr_en   = 1'b1;
      ref_wr_addr = v[3:0];
      ref_wr_data = zero ? 8'd0 : v;
      tick();
    end
    ref_wr_en = 1'b0;
  endtask

  // Start a run; poke>0 re-asserts start (and a reference write) while busy.
  task automatic run(input int qlen, input int poke, output int latency);
    int k;
    pops          = 0;
    rden_cycles   = 0;
    rden_in_stall = 0;
    fifo_drive();
    qry_len = 16'(qlen);
    start   = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!done && k < 2000) begin
      if (k == poke) begin
        start       = 1'b1;
        qry_len     = 16'd0;
        ref_wr_en   = 1'b1;
        ref_wr_addr = 4'd1;
        ref_wr_data = 8'd200;
      end
      tick();
      k++;
      start     = 1'b0;
      ref_wr_en = 1'b0;
    end
    latency = done ? k : -1;
  endtask

  task automatic expect_result(input string tag, input int exp_lat, input int exp_score,
                               input int exp_pos, input int exp_pops);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_score"}, 32'(score), 32'(exp_score));
    chk({tag, "_pos"}, 32'(score_pos), 32'(exp_pos));
    chk({tag, "_pops"}, 32'(pops), 32'(exp_pops));
    chk({tag, "_rden_cycles"}, 32'(rden_cycles), 32'(exp_pops));
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    fifo_drive();
    ARESET = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_pos", 32'(score_pos), 32'd0);
    chk("rst_rden", 32'(dtw_fifo_rden), 32'd0);
    ARESET = 1'b0;
    tick();

    load_ref(1'b0);

    // Single-sample query: exact match at column 5.
    fifo.push_back(8'd5);
    run(1, -1, lat);
    expect_result("q1", 18, 0, 5, 1);

    // Diagonal path 5,6,7 ends at column 7 with zero cost.
    fifo.push_back(8'd5); fifo.push_back(8'd6); fifo.push_back(8'd7);
    run(3, -1, lat);
    expect_result("q3", 52, 0, 7, 3);

    // Same query with the FIFO empty for 10 FETCH cycles before the 2nd sample.
    fifo.push_back(8'd5); fifo.push_back(8'd6); fifo.push_back(8'd7);
    stall_req = 1'b1;
    run(3, -1, lat);
    chk("stall_rden_low", 32'(rden_in_stall), 32'd0);
    expect_result("q3_stall", 62, 0, 7, 3);

    // Query {0,15}: row1 costs 15,14,14,...; min 14 at column 1. Busy start/write ignored.
    fifo.push_back(8'd0); fifo.push_back(8'd15);
    run(2, 5, lat);
    expect_result("q2_busy_start", 35, 14, 1, 2);

    // Zero-length query: immediate done with all-ones score, no pops.
    run(0, -1, lat);
    expect_result("qlen0", 0, 255, 0, 0);

    // Saturation: every cell clamps at 255, tie resolves to column 0.
    load_ref(1'b1);
    fifo.push_back(8'd255); fifo.push_back(8'd255);
    run(2, -1, lat);
    expect_result("sat", 35, 255, 0, 2);

    // Abort mid-ROW, then rerun to show the reference bank survived reset.
    load_ref(1'b0);
    fifo.push_back(8'd5);
    fifo_drive();
    qry_len = 16'd1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre_abort_busy", 32'(busy), 32'd1);
    ARESET = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_score", 32'(score), 32'd0);
    chk("abort_rden", 32'(dtw_fifo_rden), 32'd0);
    ARESET = 1'b0;
    tick();
    fifo.push_back(8'd5);
    run(1, -1, lat);
    expect_result("after_abort", 18, 0, 5, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
